imem_loader: RTL

//   Write side of the instruction memory. Receives a byte stream from a host
//   (UART/debug bridge) and assembles each 4 bytes, big-endian, into one 32-bit

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//   in_valid / in_data / in_ready : host byte stream (valid/ready handshake)
//   wr_en / wr_addr / wr_data     : single-word write port into instruction memory
// master: the host/memory side; slave: the loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words and
// writes them to consecutive word-aligned addresses while holding the CPU in stall.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle load request (sampled only when idle)
//   base_addr         byte address of the first word (sampled with start)
//   word_count        number of words to load (sampled with start)
//   abort             cancel the current load
//   bus (slave)       byte stream in (in_valid/in_data/in_ready), write port out
//                     (wr_en/wr_addr/wr_data)
//   busy              load in progress (CPU stall)
//   done              one-cycle pulse when a load completes
//   err               sticky: last start was rejected; cleared by the next accepted start
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  imem_loader_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Range check is done wide enough that base index + count can never wrap.
  localparam int unsigned SumW = CNT_W + 31;

  typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

  state_e           state_q;
  logic [1:0]       byte_idx_q;
  logic [31:0]      cur_addr_q;
  logic [CNT_W-1:0] rem_q;
  logic [23:0]      asm_q;       // first three bytes of the word; byte 3 goes straight out
  logic             in_ready_q;
  logic             wr_en_q;
  logic [31:0]      wr_addr_q;
  logic [31:0]      wr_data_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [SumW-1:0]  end_idx;
  logic             start_bad;

  assign end_idx   = SumW'(base_addr[31:2]) + SumW'(word_count);
  assign start_bad = (base_addr[1:0] != 2'b00) || (end_idx > SumW'(DEPTH_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      byte_idx_q <= 2'd0;
      cur_addr_q <= 32'd0;
      rem_q      <= '0;
      asm_q      <= 24'd0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (start_bad) begin
              err_q <= 1'b1;
            end else if (word_count == '0) begin
              err_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              err_q      <= 1'b0;
              cur_addr_q <= base_addr;
              rem_q      <= word_count;
              byte_idx_q <= 2'd0;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= StCollect;
            end
          end
        end
        StCollect: begin
          if (abort) begin
            byte_idx_q <= 2'd0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= StIdle;
          end else if (bus.in_valid) begin
            asm_q      <= {asm_q[15:0], bus.in_data};
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              in_ready_q <= 1'b0;
              wr_en_q    <= 1'b1;
              wr_addr_q  <= cur_addr_q;
              wr_data_q  <= {asm_q, bus.in_data};
              state_q    <= StWrite;
            end
          end
        end
        StWrite: begin
          byte_idx_q <= 2'd0;
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cur_addr_q <= cur_addr_q + 32'd4;
            rem_q      <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= StCollect;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // An abort arriving during the write cycle suppresses the strobe, so a cancelled
  // word never reaches memory.
  assign bus.wr_en    = wr_en_q & ~abort;
  assign bus.in_ready = in_ready_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
